// File: rtl/xor_rx_decrypt.sv
// Serial frame receiver that XORs the captured frame with a serially loaded, replicated key.
// Define XOR_RX_DECRYPT_EN to apply the key; when undefined the raw frame is presented.
module xor_rx_decrypt #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 8,
  localparam int CW  = $clog2(MSG_SIZE) + 1,
  localparam int KCW = $clog2(KEY_SIZE) + 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iSerial_in,
  input  logic                iSerial_flag,
  input  logic                iKey_in,
  input  logic                iLoad_key,
  input  logic                iReady,
  output logic [MSG_SIZE-1:0] oData,
  output logic                oValid,
  output logic                oKey_ready,
  output logic [CW-1:0]       oBit_count,
  output logic                oFrame_err,
  output logic                oOverrun
);

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

  state_t              state;
  logic [MSG_SIZE-1:0] frame_q;
  logic [MSG_SIZE-1:0] frame_nxt;
  logic [MSG_SIZE-1:0] key_mask;
  logic [KEY_SIZE-1:0] key_q;
  logic [KCW-1:0]      key_cnt;
  logic                load_d;

  assign frame_nxt  = {frame_q[MSG_SIZE-2:0], iSerial_in};
  assign oKey_ready = (key_cnt == KCW'(KEY_SIZE));

`ifdef XOR_RX_DECRYPT_EN
  assign key_mask = {(MSG_SIZE/KEY_SIZE){key_q}};
`else
  logic unused_key;
  assign unused_key = ^key_q;
  assign key_mask   = '0;
`endif

  // Key shifter: a fresh iLoad_key burst after a complete key restarts the count with this bit.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      key_q   <= '0;
      key_cnt <= '0;
      load_d  <= 1'b0;
    end else if (iEn) begin
      load_d <= iLoad_key;
      if (iLoad_key) begin
        key_q <= {key_q[KEY_SIZE-2:0], iKey_in};
        if (!load_d && oKey_ready)
          key_cnt <= KCW'(1);
        else if (!oKey_ready)
          key_cnt <= key_cnt + KCW'(1);
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state      <= IDLE;
      frame_q    <= '0;
      oData      <= '0;
      oValid     <= 1'b0;
      oBit_count <= '0;
      oFrame_err <= 1'b0;
      oOverrun   <= 1'b0;
    end else if (iEn) begin
      oFrame_err <= 1'b0;
      oOverrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (iSerial_flag) begin
            frame_q    <= frame_nxt;
            oBit_count <= CW'(1);
            state      <= RECV;
          end
        end
        RECV: begin
          if (iSerial_flag) begin
            frame_q    <= frame_nxt;
            oBit_count <= oBit_count + CW'(1);
            // Key is sampled in the same cycle the last bit lands
            if (oBit_count == CW'(MSG_SIZE - 1)) begin
              oData  <= frame_nxt ^ key_mask;
              oValid <= 1'b1;
              state  <= HOLD;
            end
          end else begin
            oFrame_err <= 1'b1;
            oBit_count <= '0;
            state      <= IDLE;
          end
        end
        HOLD: begin
          if (iSerial_flag)
            oOverrun <= 1'b1;
          if (iReady) begin
            oValid     <= 1'b0;
            oBit_count <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
